// File: rtl/fc_layer.sv
// fc_layer: fixed-point fully-connected layer, vec_out = W*vec_in + bias.
// A single MAC is time-multiplexed across all IN_SIZE*OUT_SIZE products.
// Optional feature: define FC_LAYER_RELU_EN to clamp negative results to zero.
module fc_layer #(
   parameter int unsigned IN_SIZE    = 4,
   parameter int unsigned OUT_SIZE   = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIXED_PNT  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] vec_in  [IN_SIZE],
   input  logic signed [DATA_WIDTH-1:0] weights [OUT_SIZE][IN_SIZE],
   input  logic signed [DATA_WIDTH-1:0] bias    [OUT_SIZE],
   output logic                         busy,
   output logic                         data_valid,
   output logic signed [DATA_WIDTH-1:0] vec_out [OUT_SIZE]
);

   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(IN_SIZE) + 1;
   localparam int unsigned CW     = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
   localparam int unsigned RW     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(IN_SIZE - 1);
   localparam logic [RW-1:0] R_LAST = RW'(OUT_SIZE - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t                         state_q;
   logic [CW-1:0]                  c_q;
   logic [RW-1:0]                  r_q;
   logic signed [ACC_W-1:0]        acc_q;
   logic signed [DATA_WIDTH-1:0]   vec_q  [IN_SIZE];
   logic signed [DATA_WIDTH-1:0]   w_q    [OUT_SIZE][IN_SIZE];
   logic signed [DATA_WIDTH-1:0]   bias_q [OUT_SIZE];
   logic signed [DATA_WIDTH-1:0]   res_q  [OUT_SIZE];

   logic signed [PROD_W-1:0]       prod_c;
   logic signed [ACC_W-1:0]        sum_c;
   logic signed [ACC_W-1:0]        shift_c;
   logic signed [DATA_WIDTH-1:0]   res_c;
   logic [RW-1:0]                  r_next_c;
   logic                           in_range_c;

   // Bias is aligned to the product's 2*FIXED_PNT fraction bits.
   function automatic logic signed [ACC_W-1:0] ext_bias(input logic signed [DATA_WIDTH-1:0] b);
      return ACC_W'(b) <<< FIXED_PNT;
   endfunction

   // MAC datapath: product, accumulate, rescale, saturate (and optional ReLU).
   always_comb begin
      prod_c     = PROD_W'(vec_q[c_q]) * PROD_W'(w_q[r_q][c_q]);
      sum_c      = acc_q + ACC_W'(prod_c);
      shift_c    = sum_c >>> FIXED_PNT;
      in_range_c = (&shift_c[ACC_W-1:DATA_WIDTH-1]) || !(|shift_c[ACC_W-1:DATA_WIDTH-1]);
      if (in_range_c)
         res_c = shift_c[DATA_WIDTH-1:0];
      else if (shift_c[ACC_W-1])
         res_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         res_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef FC_LAYER_RELU_EN
      if (res_c[DATA_WIDTH-1])
         res_c = '0;
`else
`endif
      r_next_c = r_q + RW'(1);
   end

   // Control FSM with registered outputs; operands are snapshotted at start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         c_q        <= '0;
         r_q        <= '0;
         acc_q      <= '0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         for (int i = 0; i < IN_SIZE; i++) vec_q[i] <= '0;
         for (int r = 0; r < OUT_SIZE; r++) begin
            for (int c = 0; c < IN_SIZE; c++) w_q[r][c] <= '0;
            bias_q[r]  <= '0;
            res_q[r]   <= '0;
            vec_out[r] <= '0;
         end
      end else begin
         data_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  vec_q   <= vec_in;
                  w_q     <= weights;
                  bias_q  <= bias;
                  c_q     <= '0;
                  r_q     <= '0;
                  acc_q   <= ext_bias(bias[0]);
                  busy    <= 1'b1;
                  state_q <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (c_q == C_LAST) begin
                  res_q[r_q] <= res_c;
                  c_q        <= '0;
                  if (r_q == R_LAST) begin
                     for (int i = 0; i < OUT_SIZE; i++)
                        vec_out[i] <= (RW'(i) == r_q) ? res_c : res_q[i];
                     data_valid <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     r_q   <= r_next_c;
                     acc_q <= ext_bias(bias_q[r_next_c]);
                  end
               end else begin
                  c_q   <= c_q + CW'(1);
                  acc_q <= sum_c;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: directed self-checking bench for fc_layer (2x2 and 1x1 instances).
module tb_fc_layer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   always #5 clk = ~clk;

   logic signed [15:0] vin2 [2];
   logic signed [15:0] w2   [2][2];
   logic signed [15:0] b2   [2];
   logic signed [15:0] vout2[2];
   logic               busy2, dv2;

   logic signed [15:0] vin1 [1];
   logic signed [15:0] w1   [1][1];
   logic signed [15:0] b1   [1];
   logic signed [15:0] vout1[1];
   logic               busy1, dv1;

`ifdef FC_LAYER_RELU_EN
   localparam logic [15:0] NEG_SAT = 16'h0000;
   localparam logic [15:0] NEG_ONE = 16'h0000;
`else
   localparam logic [15:0] NEG_SAT = 16'h8000;
   localparam logic [15:0] NEG_ONE = 16'hFFFF;
`endif

   fc_layer #(.IN_SIZE(2), .OUT_SIZE(2), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .vec_in(vin2), .weights(w2), .bias(b2),
      .busy(busy2), .data_valid(dv2), .vec_out(vout2));

   fc_layer #(.IN_SIZE(1), .OUT_SIZE(1), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec_in(vin1), .weights(w1), .bias(b1),
      .busy(busy1), .data_valid(dv1), .vec_out(vout1));

   int n_vec = 0;
   int n_err = 0;
   int dv_cnt, dv_first, dv_last, busy_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load2(input logic [15:0] v0, v1, w00, w01, w10, w11, bb0, bb1);
      vin2[0] = v0;  vin2[1] = v1;
      w2[0][0] = w00; w2[0][1] = w01; w2[1][0] = w10; w2[1][1] = w11;
      b2[0] = bb0; b2[1] = bb1;
   endtask

   task automatic load1(input logic [15:0] v, w, bb);
      vin1[0] = v; w1[0][0] = w; b1[0] = bb;
   endtask

   // Raise start on a negedge; returns right at the start edge E0.
   task automatic go(input int sel);
      @(negedge clk);
      if (sel != 0) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
   endtask

   // Sample #1 after edges E0..E0+win; mode 1 re-pulses start with new inputs at
   // poke_at, mode 3 asserts reset at poke_at and checks the immediate effect.
   task automatic observe(input int sel, input int win, input int poke_at, input int mode,
                          output int cnt, output int first, output int last, output int bcnt);
      cnt = 0; first = -1; last = -1; bcnt = 0;
      for (int k = 0; k <= win; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         if (k == 0) begin start1 = 1'b0; start2 = 1'b0; end
         if (mode == 1 && k == poke_at) begin
            load2(16'h0300, 16'hFF00, 16'h0100, 16'h0100, 16'h0200, 16'h0000, 16'h0010, 16'hFF00);
            start2 = 1'b1;
         end
         if (mode == 1 && k == poke_at + 1) start2 = 1'b0;
         if (mode == 3 && k == poke_at) begin
            rst_n = 1'b0;
            #1;
            chk("midrst_busy", 16'(busy2), 16'h0);
            chk("midrst_dv", 16'(dv2), 16'h0);
            chk("midrst_vout0", vout2[0], 16'h0000);
            chk("midrst_vout1", vout2[1], 16'h0000);
         end
         if ((sel != 0) ? dv1 : dv2) begin
            cnt++;
            if (first < 0) first = k;
            last = k;
         end
         if ((sel != 0) ? busy1 : busy2) bcnt++;
      end
   endtask

   initial begin
      load2(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      load1(16'h0, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy2", 16'(busy2), 16'h0);
      chk("rst_dv2", 16'(dv2), 16'h0);
      chk("rst_vout2_0", vout2[0], 16'h0);
      chk("rst_vout2_1", vout2[1], 16'h0);
      chk("rst_busy1", 16'(busy1), 16'h0);
      chk("rst_vout1", vout1[0], 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 2x2 run: latency, pulse width, busy length and values.
      load2(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0040);
      go(0);
      observe(0, 10, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("basic_dv_cnt", 16'(dv_cnt), 16'd1);
      chk("basic_dv_at", 16'(dv_first), 16'd4);
      chk("basic_busy", 16'(busy_cnt), 16'd5);
      chk("basic_out0", vout2[0], 16'h0100);
      chk("basic_out1", vout2[1], 16'h01C0);

      // Start re-asserted mid-run with different inputs: ignored.
      load2(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0040);
      go(0);
      observe(0, 12, 2, 1, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("busy_start_dv_cnt", 16'(dv_cnt), 16'd1);
      chk("busy_start_dv_at", 16'(dv_first), 16'd4);
      chk("busy_start_out0", vout2[0], 16'h0100);
      chk("busy_start_out1", vout2[1], 16'h01C0);

      // Positive saturation.
      load2(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0000, 16'h0000);
      go(0);
      observe(0, 8, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("satp_dv_cnt", 16'(dv_cnt), 16'd1);
      chk("satp_out0", vout2[0], 16'h7FFF);
      chk("satp_out1", vout2[1], 16'h7FFF);

      // Negative saturation.
      load2(16'h7F00, 16'h7F00, 16'h8100, 16'h8100, 16'h8100, 16'h8100, 16'h0000, 16'h0000);
      go(0);
      observe(0, 8, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("satn_dv_cnt", 16'(dv_cnt), 16'd1);
      chk("satn_out0", vout2[0], NEG_SAT);
      chk("satn_out1", vout2[1], NEG_SAT);

      // Back-to-back: second start on the first IDLE cycle after DONE.
      load2(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0040);
      go(0);
      observe(0, 14, 5, 1, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("b2b_dv_cnt", 16'(dv_cnt), 16'd2);
      chk("b2b_dv_first", 16'(dv_first), 16'd4);
      chk("b2b_gap", 16'(dv_last - dv_first), 16'd6);
      chk("b2b_out0", vout2[0], 16'h0210);
      chk("b2b_out1", vout2[1], 16'h0500);

      // Reset mid-run, then a clean run with normal latency.
      load2(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0040);
      go(0);
      observe(0, 8, 2, 3, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("midrst_no_dv", 16'(dv_cnt), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      go(0);
      observe(0, 8, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("postrst_dv_at", 16'(dv_first), 16'd4);
      chk("postrst_out0", vout2[0], 16'h0100);
      chk("postrst_out1", vout2[1], 16'h01C0);

      // 1x1 truncation toward -inf.
      load1(16'h0001, 16'h0080, 16'h0000);
      go(1);
      observe(1, 5, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("trunc_pos_dv_at", 16'(dv_first), 16'd1);
      chk("trunc_pos_busy", 16'(busy_cnt), 16'd2);
      chk("trunc_pos_out", vout1[0], 16'h0000);
      load1(16'hFFFF, 16'h0080, 16'h0000);
      go(1);
      observe(1, 5, -1, 0, dv_cnt, dv_first, dv_last, busy_cnt);
      chk("trunc_neg_dv_cnt", 16'(dv_cnt), 16'd1);
      chk("trunc_neg_out", vout1[0], NEG_ONE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
